// File: rtl/n2m_bit_scan_enc.sv
// Sequential multi-hit encoder: accepts an N-bit vector and emits the index of
// every set bit, one beat per cycle, in LSB-first or MSB-first order.
module n2m_bit_scan_enc #(
  parameter int unsigned N = 42,
  parameter int unsigned M = 6
) (
  input  logic         Clk_i,
  input  logic         Rst_i,
  input  logic         In_Vld_i,
  output logic         In_Rdy_o,
  input  logic [N-1:0] In_Dat_i,
  input  logic         In_Msb_i,
  output logic         Out_Vld_o,
  input  logic         Out_Rdy_i,
  output logic [M-1:0] Out_Idx_o,
  output logic [M-1:0] Out_Seq_o,
  output logic         Out_Last_o,
  output logic         Out_Empty_o
);

  if ((2 ** M) < N) begin : g_width_check
    $error("n2m_bit_scan_enc: 2**M must be >= N");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state, state_next;
  logic [N-1:0]   work;
  logic           msb_q;
  logic [N-1:0]   search_vec;
  logic           search_msb;
  logic [M-1:0]   first;
  logic           found;
  logic [N-1:0]   rest;
  logic           accept;
  logic           consume;
  logic           load;

  assign In_Rdy_o = (state == IDLE) && (!Out_Vld_o || Out_Rdy_i);
  assign accept   = In_Vld_i && In_Rdy_o;
  assign consume  = Out_Vld_o && Out_Rdy_i;
  assign load     = accept || ((state == SCAN) && consume);

  // One shared priority search: the fresh vector in IDLE, the work vector in SCAN.
  assign search_vec = (state == IDLE) ? In_Dat_i : work;
  assign search_msb = (state == IDLE) ? In_Msb_i : msb_q;

  always_comb begin
    first = '0;
    found = 1'b0;
    if (search_msb) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (search_vec[i]) begin
          first = M'(i);
          found = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = N; i > 0; i--) begin
        if (search_vec[i-1]) begin
          first = M'(i - 1);
          found = 1'b1;
        end
      end
    end
    rest = search_vec;
    if (found) rest[first] = 1'b0;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      state_next = (rest != '0) ? SCAN : IDLE;
    end else if ((state == SCAN) && consume && (rest == '0)) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A zero vector falls out of the same path: found=0 gives Idx=0, Last=1, Empty=1.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      work        <= '0;
      msb_q       <= 1'b0;
      Out_Vld_o   <= 1'b0;
      Out_Idx_o   <= '0;
      Out_Seq_o   <= '0;
      Out_Last_o  <= 1'b0;
      Out_Empty_o <= 1'b0;
    end else if (load) begin
      work        <= rest;
      Out_Vld_o   <= 1'b1;
      Out_Idx_o   <= first;
      Out_Last_o  <= (rest == '0);
      Out_Empty_o <= !found;
      if (accept) begin
        msb_q     <= In_Msb_i;
        Out_Seq_o <= '0;
      end else begin
        Out_Seq_o <= Out_Seq_o + M'(1);
      end
    end else if (consume) begin
      Out_Vld_o <= 1'b0;
    end
  end

endmodule
